// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_I = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] RESP_I = 3'd3;
  localparam logic [2:0] RESP_D = 3'd4;

  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]    state_r,     state_s;
  logic [CW-1:0] cnt_r,       cnt_s;
  logic          mem_req_r,   mem_req_s;
  logic          mem_we_r,    mem_we_s;
  logic [AW-1:0] mem_addr_r,  mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic          i_ack_r,     i_ack_s;
  logic [DW-1:0] i_rdata_r,   i_rdata_s;
  logic          d_ack_r,     d_ack_s;
  logic [DW-1:0] d_rdata_r,   d_rdata_s;
  logic          d_win_s;
  logic [CW-1:0] cnt_inc_s;

  assign d_win_s   = d_req & (~i_req | (cnt_r < LIMIT));
  assign cnt_inc_s = (cnt_r >= LIMIT) ? LIMIT : (cnt_r + CNT_ONE);

  // Next-state and next-output computation for the grant/transfer/response sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    i_ack_s     = 1'b0;
    i_rdata_s   = i_rdata_r;
    d_ack_s     = 1'b0;
    d_rdata_s   = d_rdata_r;
    case (state_r)
      IDLE: begin
        if (d_win_s) begin
          state_s     = BUSY_D;
          mem_req_s   = 1'b1;
          mem_we_s    = d_we;
          mem_addr_s  = d_addr;
          mem_wdata_s = d_wdata;
          cnt_s       = i_req ? cnt_inc_s : {CW{1'b0}};
        end else if (i_req) begin
          state_s     = BUSY_I;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = i_addr;
          mem_wdata_s = {DW{1'b0}};
          cnt_s       = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_s   = RESP_I;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          i_ack_s   = 1'b1;
          i_rdata_s = mem_rdata;
        end else begin
          state_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_s   = RESP_D;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          d_ack_s   = 1'b1;
          // Stores leave the last load result visible.
          if (!mem_we_r) begin
            d_rdata_s = mem_rdata;
          end else begin
            d_rdata_s = d_rdata_r;
          end
        end else begin
          state_s = BUSY_D;
        end
      end
      RESP_I, RESP_D: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      i_ack_r     <= 1'b0;
      i_rdata_r   <= {DW{1'b0}};
      d_ack_r     <= 1'b0;
      d_rdata_r   <= {DW{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      i_ack_r     <= i_ack_s;
      i_rdata_r   <= i_rdata_s;
      d_ack_r     <= d_ack_s;
      d_rdata_r   <= d_rdata_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign i_ack     = i_ack_r;
  assign i_rdata   = i_rdata_r;
  assign d_ack     = d_ack_r;
  assign d_rdata   = d_rdata_r;
  assign i_stall   = i_req & ~i_ack_r;
  assign d_stall   = d_req & ~d_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table followed by
// hand-written sequences for contention, back-pressure, mid-transfer reset and stray acks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, i_stall, d_stall, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } stim_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        i_stall;
    logic        d_stall;
  } resp_t;

  typedef struct packed {
    stim_t stim;
    resp_t want;
  } vec_t;

  resp_t out_s;
  assign out_s = '{mem_req, mem_we, mem_addr, mem_wdata, i_ack, i_rdata, d_ack, d_rdata, i_stall, d_stall};

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] req);
    assert_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic apply(input stim_t s);
    i_req = s.i_req; i_addr = s.i_addr;
    d_req = s.d_req; d_we = s.d_we; d_addr = s.d_addr; d_wdata = s.d_wdata;
    mem_ack = s.mem_ack; mem_rdata = s.mem_rdata;
  endtask

  // Waits (bounded) for mem_req, sampling 1 time unit after each rising edge.
  task automatic wait_mem_req(input string name);
    int k;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (mem_req !== 1'b1) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL %s: got mem_req=%b expected 1 within 20 cycles", name, mem_req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[19];
    vecs[0]  = '{'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b1, 1'b0, 32'h40, 32'h0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0}};
    vecs[1]  = vecs[0];
    vecs[2]  = '{'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h00500113},
                 '{1'b0, 1'b0, 32'h40, 32'h0,  1'b1, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b0}};
    vecs[3]  = '{'{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b0, 1'b0, 32'h40, 32'h0,  1'b0, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b0}};
    vecs[4]  = '{'{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'hDEADBEEF},
                 '{1'b0, 1'b0, 32'h40, 32'h0,  1'b0, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b0}};
    vecs[5]  = vecs[4];
    vecs[6]  = '{'{1'b0, 32'h0,  1'b1, 1'b1, 32'h64, 32'h7,  1'b0, 32'h0},
                 '{1'b1, 1'b1, 32'h64, 32'h7,  1'b0, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b1}};
    vecs[7]  = vecs[6];
    vecs[8]  = '{'{1'b0, 32'h0,  1'b1, 1'b1, 32'h64, 32'h7,  1'b1, 32'hBAD0BAD0},
                 '{1'b0, 1'b0, 32'h64, 32'h7,  1'b0, 32'h00500113, 1'b1, 32'h0,        1'b0, 1'b0}};
    vecs[9]  = '{'{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b0, 1'b0, 32'h64, 32'h7,  1'b0, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b0}};
    vecs[10] = '{'{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h55, 1'b0, 32'h0},
                 '{1'b1, 1'b0, 32'h80, 32'h55, 1'b0, 32'h00500113, 1'b0, 32'h0,        1'b0, 1'b1}};
    vecs[11] = '{'{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h55, 1'b1, 32'h12345678},
                 '{1'b0, 1'b0, 32'h80, 32'h55, 1'b0, 32'h00500113, 1'b1, 32'h12345678, 1'b0, 1'b0}};
    vecs[12] = '{'{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b0, 1'b0, 32'h80, 32'h55, 1'b0, 32'h00500113, 1'b0, 32'h12345678, 1'b0, 1'b0}};
    vecs[13] = '{'{1'b1, 32'h44, 1'b1, 1'b0, 32'h90, 32'h0,  1'b0, 32'h0},
                 '{1'b1, 1'b0, 32'h90, 32'h0,  1'b0, 32'h00500113, 1'b0, 32'h12345678, 1'b1, 1'b1}};
    vecs[14] = '{'{1'b1, 32'h44, 1'b1, 1'b0, 32'h90, 32'h0,  1'b1, 32'hCAFE0001},
                 '{1'b0, 1'b0, 32'h90, 32'h0,  1'b0, 32'h00500113, 1'b1, 32'hCAFE0001, 1'b1, 1'b0}};
    vecs[15] = '{'{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b0, 1'b0, 32'h90, 32'h0,  1'b0, 32'h00500113, 1'b0, 32'hCAFE0001, 1'b1, 1'b0}};
    vecs[16] = '{'{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b1, 1'b0, 32'h44, 32'h0,  1'b0, 32'h00500113, 1'b0, 32'hCAFE0001, 1'b1, 1'b0}};
    vecs[17] = '{'{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h00A00093},
                 '{1'b0, 1'b0, 32'h44, 32'h0,  1'b1, 32'h00A00093, 1'b0, 32'hCAFE0001, 1'b0, 1'b0}};
    vecs[18] = '{'{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0},
                 '{1'b0, 1'b0, 32'h44, 32'h0,  1'b0, 32'h00A00093, 1'b0, 32'hCAFE0001, 1'b0, 1'b0}};

    reset = 1'b0;
    apply('0);
    #12;
    check("reset_state", out_s, 134'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 19; v++) begin
      @(negedge clk);
      apply(vecs[v].stim);
      @(posedge clk); #1;
      check($sformatf("vec%0d", v), out_s, vecs[v].want);
    end

    // Contention: both requesters held, ack one cycle after each grant.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h11;
    for (int g = 0; g < 10; g++) begin
      logic is_i;
      is_i = ((g % 5) == 4);
      wait_mem_req($sformatf("contend_wait%0d", g));
      check($sformatf("contend_grant%0d", g), mem_addr, is_i ? 32'h100 : 32'h200);
      @(negedge clk);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      check($sformatf("contend_ack%0d", g), {i_ack, d_ack}, is_i ? 2'b10 : 2'b01);
      @(negedge clk);
      mem_ack = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-pressure: store held 10 cycles without ack while a fetch waits.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5;
    i_req = 1'b1; i_addr = 32'h104;
    wait_mem_req("bp_wait");
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold%0d", k),
            {mem_req, mem_we, mem_addr, mem_wdata, d_stall, i_ack, d_ack},
            {1'b1, 1'b1, 32'h300, 32'hA5, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    check("bp_ack", {mem_req, d_ack, i_ack, d_stall}, 4'b0100);
    @(negedge clk);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Reset mid-fetch: the pending fetch is granted next, then reset is asserted.
    wait_mem_req("rst_wait");
    check("rst_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h104});
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0;
    #1;
    check("rst_async", out_s, 134'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ack = (k == 1);
      mem_rdata = 32'h77;
      @(posedge clk); #1;
      check($sformatf("rst_late_ack%0d", k), out_s, 134'd0);
    end

    // A fresh fetch is granted on the next edge, confirming the block sits in IDLE.
    @(negedge clk);
    mem_ack = 1'b0; i_req = 1'b1; i_addr = 32'h8; mem_rdata = 32'h13;
    @(posedge clk); #1;
    check("post_rst_grant", {mem_req, mem_addr}, {1'b1, 32'h8});
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ack", {i_ack, i_rdata, d_ack}, {1'b1, 32'h13, 1'b0});
    @(negedge clk);
    mem_ack = 1'b0; i_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the pipelined core's instruction-fetch port and its data port. Data requests win by default. A bounded starvation counter forces an instruction grant after STARVE_LIMIT back-to-back data wins. The block sits between riscvpipeline and the unified memory, and drives the IF/MEM stall signals consumed by the hazard unit.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending; legal range 1..15
CW, 4, width of the starvation counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  instruction-fetch request; held until i_ack
i_addr  in  AW  fetch address
i_ack  out  1  one-cycle pulse; i_rdata valid
i_rdata  out  DW  fetched instruction
i_stall  out  1  i_req & ~i_ack, combinational
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse; d_rdata valid for loads
d_rdata  out  DW  load data
d_stall  out  1  d_req & ~d_ack, combinational
mem_req  out  1  memory request; held until mem_ack is sampled
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. All outputs except the two stalls are registered.
- Reset (reset = 0, async):
  - State goes to IDLE and the starvation counter to 0.
  - mem_req, mem_we, i_ack and d_ack go to 0.
  - mem_addr, mem_wdata, i_rdata and d_rdata go to 0.
  - A mem_ack arriving after reset release while in IDLE is ignored.
- IDLE grant rule, evaluated at the clock edge:
  - d_req & (~i_req | cnt < STARVE_LIMIT) -> BUSY_D.
  - Otherwise, i_req -> BUSY_I.
  - Otherwise, stay in IDLE.
- On entering BUSY_x:
  - mem_req = 1.
  - mem_addr and mem_wdata capture the winner's request; mem_we = d_we for data, 0 for instruction.
  - Captured values stay stable until mem_ack.
- Starvation counter, updated at grant:
  - Data grant with i_req = 1 -> cnt + 1, saturating at STARVE_LIMIT.
  - Data grant with i_req = 0 -> cnt = 0.
  - Instruction grant -> cnt = 0.
- BUSY_x with mem_ack = 1 -> RESP_x.
  - mem_req and mem_we drop to 0.
  - The winner's rdata register captures mem_rdata; for stores the capture is don't-care and d_rdata is held.
- RESP_x:
  - The winner's ack = 1 for exactly this cycle.
  - No new grant is made; next state is IDLE.
  - The requester deasserts or changes req in the following cycle.
- Latency:
  - Request first visible in IDLE at cycle N -> mem_req high at N+1.
  - mem_ack at cycle M -> ack high at M+1.
  - Next grant is decided no earlier than M+2, so minimum turnaround is 4 cycles with mem_ack at N+1.
- mem_ack is ignored in IDLE and RESP states.
- Request-side changes do not affect an in-flight transaction: changing d_req or i_req while BUSY has no effect until the next IDLE.
- Simultaneous i_req and d_req with cnt = 0 -> data wins.
- Reset asserted mid-BUSY: the transaction is abandoned, no ack is issued, and the requester must re-request.
- i_rdata and d_rdata hold their last captured value between acks.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x40, mem_ack 2 cycles after mem_req with mem_rdata = 0x00500113 -> mem_addr = 0x40, mem_we = 0, i_ack pulses 1 cycle later with i_rdata = 0x00500113, i_stall low afterwards.
- Store: d_req = 1, d_we = 1, d_addr = 0x64, d_wdata = 7 -> mem_we = 1, mem_addr = 0x64, mem_wdata = 7 held until mem_ack; d_ack 1 cycle later; i_ack never asserts.
- Contention: i_req and d_req both held continuously, mem_ack always 1 cycle after mem_req, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I; counter returns to 0 after each I.
- Back-pressure: mem_ack withheld 10 cycles during BUSY_D -> mem_req, mem_addr and mem_we stay constant; d_stall = 1 for the whole interval; no i grant occurs.
- Reset mid-op: reset driven low in BUSY_I, then a late mem_ack 2 cycles after release -> all outputs 0, state IDLE, no i_ack pulse.
- Stray ack: mem_ack = 1 while IDLE with no requests -> no ack outputs and no state change.
